// File: rtl/pwm_peripheral.sv
// 16-channel output stage: each bit forced low, held high, or driven by one shared 8-bit PWM waveform.
// Optional macro PWM_SYNC_UPDATE_EN shadows the duty value so it only changes at a period boundary.
module pwm_peripheral #(
    parameter int unsigned PRESCALE = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int unsigned PRESC_W = 16;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned OUT_W   = 16;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(255);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               period_start_q, period_start_d;
    logic [CNT_W-1:0]   duty_act_c;
    logic               tick_c;
    logic               wrap_c;
    logic               pwm_c;
    logic [OUT_W-1:0]   en_out_c;
    logic [OUT_W-1:0]   en_pwm_c;

    // Prescaler and period counter advance together; wrap marks the last step of a period.
    always_comb begin
        tick_c    = 1'b0;
        wrap_c    = 1'b0;
        presc_d   = presc_q;
        pwm_cnt_d = pwm_cnt_q;
        tick_c    = (presc_q == PRESC_LAST);
        wrap_c    = tick_c && (pwm_cnt_q == CNT_LAST);
        if (tick_c) begin
            presc_d   = '0;
            pwm_cnt_d = pwm_cnt_q + CNT_W'(1);
        end else begin
            presc_d   = presc_q + PRESC_W'(1);
        end
    end

`ifdef PWM_SYNC_UPDATE_EN
    logic [CNT_W-1:0] duty_q, duty_d;

    // Shadow duty is loaded on the wrap edge, so it first applies at pwm_cnt=0.
    always_comb begin
        duty_d = duty_q;
        if (wrap_c) begin
            duty_d = pwm_duty_cycle;
        end
        duty_act_c = duty_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end
`else
    always_comb begin
        duty_act_c = pwm_duty_cycle;
    end
`endif

    // 0xFF is treated as fully on rather than 255/256.
    always_comb begin
        pwm_c          = 1'b0;
        en_out_c       = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm_c       = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        pwm_c          = (duty_act_c == CNT_W'(255)) || (pwm_cnt_q < duty_act_c);
        out_d          = en_out_c & (~en_pwm_c | {OUT_W{pwm_c}});
        period_start_d = wrap_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q        <= '0;
            pwm_cnt_q      <= '0;
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            pwm_cnt_q      <= pwm_cnt_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral at the default PRESCALE of 13 (3328 clk per period).
module tb_pwm_peripheral;

    localparam int unsigned PERIOD = 3328;

    typedef struct {
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [7:0]  duty;
        logic [15:0] exp_out;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out_s;
    logic        period_start_s;

    int checks;
    int failures;

    pwm_peripheral #(.PRESCALE(13)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out_s),
        .period_start    (period_start_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        en_reg_out_7_0  = eo[7:0];
        en_reg_out_15_8 = eo[15:8];
        en_reg_pwm_7_0  = ep[7:0];
        en_reg_pwm_15_8 = ep[15:8];
        pwm_duty_cycle  = d;
    endtask

    // Advance until period_start is sampled high; bounded by a little over one period.
    task automatic wait_ps(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < PERIOD + 16; k++) begin
            step();
            if (period_start_s) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s: period_start timeout, got 0, expected 1", name);
        end
    endtask

    // Called right after period_start was sampled: observes one full period of out.
    task automatic run_period(output int highs, output int upper_nz, output int ps_bad);
        highs    = 0;
        upper_nz = 0;
        ps_bad   = 0;
        for (int k = 1; k <= int'(PERIOD); k++) begin
            step();
            if (out_s[0]) highs++;
            if (out_s[15:1] != 15'h0) upper_nz++;
            if ((k == int'(PERIOD)) != period_start_s) ps_bad++;
        end
    endtask

    task automatic settle();
`ifdef PWM_SYNC_UPDATE_EN
        wait_ps("settle");
        step();
`else
        step();
        step();
`endif
    endtask

    vec_t vecs[9];
    int   highs;
    int   upper_nz;
    int   ps_bad;
    int   tot;

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0] = '{16'hFFFF, 16'h0000, 8'h80, 16'hFFFF};
        vecs[1] = '{16'h0000, 16'hFFFF, 8'hFF, 16'h0000};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 8'hFF, 16'hFFFF};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 8'h00, 16'h0000};
        vecs[4] = '{16'h00FF, 16'h0F0F, 8'h00, 16'h00F0};
        vecs[5] = '{16'hA5A5, 16'hFFFF, 8'hFF, 16'hA5A5};
        vecs[6] = '{16'hFF00, 16'h00F0, 8'h00, 16'hFF00};
        vecs[7] = '{16'h1234, 16'h1030, 8'h00, 16'h0204};
        vecs[8] = '{16'h1234, 16'h1030, 8'hFF, 16'h1234};

        rst_n = 1'b0;
        apply(16'hFFFF, 16'h0000, 8'h80);
        #23;
        check("reset_out", 32'(out_s), 32'h0);
        check("reset_period_start", 32'(period_start_s), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            apply(vecs[i].en_out, vecs[i].en_pwm, vecs[i].duty);
            settle();
            check($sformatf("vec%0d_out", i), 32'(out_s), 32'(vecs[i].exp_out));
        end

        // Half duty on bit 0: high 1664, low 1664, period 3328.
        apply(16'h0001, 16'h0001, 8'h80);
        wait_ps("duty80_align");
        run_period(highs, upper_nz, ps_bad);
        check("duty80_high", 32'(highs), 32'd1664);
        check("duty80_upper_zero", 32'(upper_nz), 32'd0);
        check("duty80_period_start", 32'(ps_bad), 32'd0);

        apply(16'h0001, 16'h0001, 8'h00);
        wait_ps("duty00_align");
        tot = 0;
        for (int p = 0; p < 2; p++) begin
            run_period(highs, upper_nz, ps_bad);
            tot += highs;
        end
        check("duty00_high", 32'(tot), 32'd0);

        apply(16'h0001, 16'h0001, 8'hFF);
        wait_ps("dutyFF_align");
        tot = 0;
        for (int p = 0; p < 2; p++) begin
            run_period(highs, upper_nz, ps_bad);
            tot += highs;
        end
        check("dutyFF_high", 32'(tot), 32'd6656);

        apply(16'h0001, 16'h0001, 8'h01);
        wait_ps("duty01_align");
        for (int p = 0; p < 2; p++) begin
            run_period(highs, upper_nz, ps_bad);
            check($sformatf("duty01_high_p%0d", p), 32'(highs), 32'd13);
            check($sformatf("duty01_period_start_p%0d", p), 32'(ps_bad), 32'd0);
        end

        // Duty 0x40 -> 0xC0 at pwm_cnt=0x20.
        apply(16'h0001, 16'h0001, 8'h40);
        wait_ps("dutychg_align");
        tot = 0;
        for (int k = 1; k <= 416; k++) begin
            step();
            if (out_s[0]) tot++;
        end
        pwm_duty_cycle = 8'hC0;
        for (int k = 417; k <= int'(PERIOD); k++) begin
            step();
            if (out_s[0]) tot++;
        end
        check("dutychg_period_start", 32'(period_start_s), 32'd1);
`ifdef PWM_SYNC_UPDATE_EN
        check("dutychg_cur_high", 32'(tot), 32'd832);
`else
        check("dutychg_cur_high", 32'(tot), 32'd2496);
`endif
        run_period(highs, upper_nz, ps_bad);
        check("dutychg_next_high", 32'(highs), 32'd2496);

        // Async reset mid-high-phase at pwm_cnt=0x50.
        apply(16'h0001, 16'h0001, 8'h80);
        wait_ps("rst_align");
        for (int k = 0; k < 1040; k++) step();
        check("rst_pre_high", 32'(out_s[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_out", 32'(out_s), 32'h0);
        check("rst_async_ps", 32'(period_start_s), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_period(highs, upper_nz, ps_bad);
`ifdef PWM_SYNC_UPDATE_EN
        check("rst_first_high", 32'(highs), 32'd0);
`else
        check("rst_first_high", 32'(highs), 32'd1664);
`endif
        check("rst_period_start", 32'(ps_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
